axis_bayer_phase_extractor: RTL and testbench

AXI4-Stream video block that decimates a raw Bayer/mosaic stream by a factor of C_DECIM in both directions. It keeps only the pixels at a runtime-selectable (column, row) phase, so any one colour plane can be pulled out of the mosaic. Output tlast is regenerated on the last kept pixel of each kept row, even when that pixel is not the last input pixel of the row. A bypass mode passes the stream through. The block sits between the sensor/deframer stream and downstream per-plane processing.

---
 rtl/axis_bayer_phase_extractor_pkg.sv | 18 +
 rtl/axis_bayer_phase_extractor_if.sv | 15 +
 rtl/axis_bayer_outfifo.sv | 78 +++++++
 rtl/axis_bayer_phase_extractor.sv | 149 ++++++++++++++
 tb/tb_axis_bayer_phase_extractor.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/axis_bayer_phase_extractor_pkg.sv
// Shared constants and record types for the Bayer phase extractor and its output FIFO.
package axis_bayer_phase_extractor_pkg;

  localparam int unsigned FifoDepth   = 4;
  localparam int unsigned ReadyThresh = 2;
  localparam int unsigned CountWidth  = $clog2(FifoDepth + 1);

  // Sideband part of an output entry; the data field is added where the pixel width is known.
  typedef struct packed {
    logic user;
    logic last;
  } beat_tag_t;

  function automatic int unsigned phase_mod(input int unsigned phase, input int unsigned decim);
    return phase % decim;
  endfunction

endpackage

// File: rtl/axis_bayer_phase_extractor_if.sv
// AXI4-Stream video bus (tdata/tuser/tlast with valid/ready handshake).
interface axis_bayer_phase_extractor_if #(
  parameter int unsigned C_PIXEL_WIDTH = 8
) ();

  logic [C_PIXEL_WIDTH-1:0] tdata;
  logic                     tuser;
  logic                     tlast;
  logic                     tvalid;
  logic                     tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axis_bayer_outfifo.sv
// Four-entry shift FIFO with two ordered push ports per cycle; head entry drives m_axis directly.
module axis_bayer_outfifo
  import axis_bayer_phase_extractor_pkg::*;
#(
  parameter int unsigned C_PIXEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0,
  input  logic [C_PIXEL_WIDTH-1:0] push0_data,
  input  beat_tag_t                push0_tag,
  input  logic                     push1,
  input  logic [C_PIXEL_WIDTH-1:0] push1_data,
  input  beat_tag_t                push1_tag,
  output logic [CountWidth-1:0]    count,
  axis_bayer_phase_extractor_if.master m_axis
);

  typedef struct packed {
    logic [C_PIXEL_WIDTH-1:0] data;
    beat_tag_t                tag;
  } entry_t;

  entry_t                mem_q [FifoDepth];
  entry_t                mem_d [FifoDepth];
  logic [FifoDepth-1:0]  vld_q, vld_d;
  logic [CountWidth-1:0] count_q, count_d, base;
  logic                  pop;

  assign pop  = vld_q[0] & m_axis.tready;
  assign base = count_q - CountWidth'(pop);

  // Pop shifts toward the head first, then pushes land in the first free slots in order.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    if (pop) begin
      for (int unsigned i = 0; i < FifoDepth - 1; i++) begin
        mem_d[i] = mem_q[i + 1];
        vld_d[i] = vld_q[i + 1];
      end
      mem_d[FifoDepth - 1] = '0;
      vld_d[FifoDepth - 1] = 1'b0;
    end
    for (int unsigned i = 0; i < FifoDepth; i++) begin
      if (push0 && (CountWidth'(i) == base)) begin
        mem_d[i] = {push0_data, push0_tag};
        vld_d[i] = 1'b1;
      end
      if (push1 && (CountWidth'(i) == base + 1'b1)) begin
        mem_d[i] = {push1_data, push1_tag};
        vld_d[i] = 1'b1;
      end
    end
    count_d = base + CountWidth'(push0) + CountWidth'(push1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  assign count         = count_q;
  assign m_axis.tvalid = vld_q[0];
  assign m_axis.tdata  = mem_q[0].data;
  assign m_axis.tuser  = mem_q[0].tag.user;
  assign m_axis.tlast  = mem_q[0].tag.last;

endmodule

// File: rtl/axis_bayer_phase_extractor.sv
// Keeps one (column, row) phase of a Bayer mosaic, decimating by C_DECIM per axis, and
// regenerates tlast on the last kept pixel of each kept row.
module axis_bayer_phase_extractor
  import axis_bayer_phase_extractor_pkg::*;
#(
  parameter int unsigned C_PIXEL_WIDTH = 8,
  parameter int unsigned C_DECIM       = 2,
  parameter int unsigned C_PHASE_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [C_PHASE_WIDTH-1:0] col_phase,
  input  logic [C_PHASE_WIDTH-1:0] row_phase,
  input  logic                     bypass,
  axis_bayer_phase_extractor_if.slave  s_axis,
  axis_bayer_phase_extractor_if.master m_axis
);

  localparam int unsigned IdxWidth = (C_DECIM > 2) ? $clog2(C_DECIM) : 1;
  localparam logic [IdxWidth-1:0] IdxMax = IdxWidth'(C_DECIM - 1);

  logic [IdxWidth-1:0]      col_idx_q, col_idx_d, row_idx_q, row_idx_d;
  logic [IdxWidth-1:0]      col_ph_q, col_ph_d, row_ph_q, row_ph_d;
  logic                     bypass_q, bypass_d;
  logic                     started_q, started_d;
  logic                     sof_flag_q, sof_flag_d;
  logic                     p_valid_q, p_valid_d, p_user_q, p_user_d;
  logic [C_PIXEL_WIDTH-1:0] p_data_q, p_data_d;

  logic                     accept, live, sof, keep, cur_user, trunc, p_push, p_last, cur_push;
  logic [IdxWidth-1:0]      col_cur, row_cur, col_inc, row_inc, cfg_col, cfg_row;
  logic                     cfg_bypass;
  logic                     push0, push1;
  logic [C_PIXEL_WIDTH-1:0] push0_data;
  beat_tag_t                push0_tag, push1_tag;
  logic [CountWidth-1:0]    fifo_count;

  assign s_axis.tready = !reset && (fifo_count <= CountWidth'(ReadyThresh));
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign sof           = s_axis.tuser;
  // Beats before the first start-of-frame after reset are dropped.
  assign live          = accept && (sof || started_q);

  // The start-of-frame beat already uses the configuration presented with it.
  assign cfg_col    = sof ? IdxWidth'(phase_mod(32'(col_phase), C_DECIM)) : col_ph_q;
  assign cfg_row    = sof ? IdxWidth'(phase_mod(32'(row_phase), C_DECIM)) : row_ph_q;
  assign cfg_bypass = sof ? bypass : bypass_q;
  assign col_cur    = sof ? '0 : col_idx_q;
  assign row_cur    = sof ? '0 : row_idx_q;
  assign col_inc    = (col_cur == IdxMax) ? '0 : col_cur + 1'b1;
  assign row_inc    = (row_cur == IdxMax) ? '0 : row_cur + 1'b1;

  assign keep     = cfg_bypass || ((col_cur == cfg_col) && (row_cur == cfg_row));
  assign cur_user = sof || sof_flag_q;

  // A new frame arriving while a pixel is held back closes the truncated row with it.
  assign trunc    = sof && p_valid_q;
  assign p_push   = p_valid_q && (trunc || keep || s_axis.tlast);
  assign p_last   = trunc || !keep;
  assign cur_push = keep && s_axis.tlast;

  assign push0      = live && (p_push || cur_push);
  assign push1      = live && p_push && cur_push;
  assign push0_data = p_push ? p_data_q : s_axis.tdata;
  assign push0_tag  = p_push ? '{user: p_user_q, last: p_last} : '{user: cur_user, last: 1'b1};
  assign push1_tag  = '{user: cur_user, last: 1'b1};

  always_comb begin
    started_d  = started_q;
    col_ph_d   = col_ph_q;
    row_ph_d   = row_ph_q;
    bypass_d   = bypass_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    sof_flag_d = sof_flag_q;
    p_valid_d  = p_valid_q;
    p_data_d   = p_data_q;
    p_user_d   = p_user_q;
    if (live) begin
      if (sof) begin
        started_d = 1'b1;
        col_ph_d  = cfg_col;
        row_ph_d  = cfg_row;
        bypass_d  = cfg_bypass;
      end
      if (s_axis.tlast) begin
        col_idx_d = '0;
        row_idx_d = row_inc;
      end else begin
        col_idx_d = col_inc;
        row_idx_d = row_cur;
      end
      if (keep) begin
        sof_flag_d = 1'b0;
      end else if (sof) begin
        sof_flag_d = 1'b1;
      end
      if (keep && !s_axis.tlast) begin
        p_valid_d = 1'b1;
        p_data_d  = s_axis.tdata;
        p_user_d  = cur_user;
      end else if (p_push || s_axis.tlast) begin
        p_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      started_q  <= 1'b0;
      col_ph_q   <= '0;
      row_ph_q   <= '0;
      bypass_q   <= 1'b0;
      col_idx_q  <= '0;
      row_idx_q  <= '0;
      sof_flag_q <= 1'b0;
      p_valid_q  <= 1'b0;
      p_data_q   <= '0;
      p_user_q   <= 1'b0;
    end else begin
      started_q  <= started_d;
      col_ph_q   <= col_ph_d;
      row_ph_q   <= row_ph_d;
      bypass_q   <= bypass_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      sof_flag_q <= sof_flag_d;
      p_valid_q  <= p_valid_d;
      p_data_q   <= p_data_d;
      p_user_q   <= p_user_d;
    end
  end

  axis_bayer_outfifo #(
    .C_PIXEL_WIDTH(C_PIXEL_WIDTH)
  ) u_outfifo (
    .clk        (clk),
    .reset      (reset),
    .push0      (push0),
    .push0_data (push0_data),
    .push0_tag  (push0_tag),
    .push1      (push1),
    .push1_data (s_axis.tdata),
    .push1_tag  (push1_tag),
    .count      (fifo_count),
    .m_axis     (m_axis)
  );

endmodule

// File: tb/tb_axis_bayer_phase_extractor.sv
// Bench for the Bayer phase extractor: frame-level reference model plus randomized handshakes.
module tb_axis_bayer_phase_extractor;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned PW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] col_phase = '0;
  logic [PW-1:0] row_phase = '0;
  logic          bypass = 1'b0;

  axis_bayer_phase_extractor_if #(.C_PIXEL_WIDTH(W)) s_if ();
  axis_bayer_phase_extractor_if #(.C_PIXEL_WIDTH(W)) m_if ();

  axis_bayer_phase_extractor #(
    .C_PIXEL_WIDTH(W),
    .C_DECIM      (D),
    .C_PHASE_WIDTH(PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col_phase(col_phase),
    .row_phase(row_phase),
    .bypass   (bypass),
    .s_axis   (s_if),
    .m_axis   (m_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  logic [W+1:0] exp_q[$];  // {data, user, last}
  logic [W-1:0] pix[0:15][0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each row emits its kept pixels in order, last on the final one; user on the first of the frame.
  function automatic void model_frame(input int w, input int h, input int last_w,
                                      input int cp, input int rp, input bit byp);
    bit first = 1'b1;
    int cols[$];
    for (int r = 0; r < h; r++) begin
      int rw = (r == h - 1) ? last_w : w;
      cols.delete();
      for (int c = 0; c < rw; c++) begin
        if (byp || (((c % D) == (cp % D)) && ((r % D) == (rp % D)))) cols.push_back(c);
      end
      for (int k = 0; k < cols.size(); k++) begin
        exp_q.push_back({pix[r][cols[k]], first, k == cols.size() - 1});
        first = 1'b0;
      end
    end
  endfunction

  always @(negedge clk) begin
    case (ready_mode)
      0:       m_if.tready = 1'b0;
      1:       m_if.tready = 1'b1;
      default: m_if.tready = ($urandom_range(0, 3) != 0);
    endcase
    if (!reset && m_if.tvalid && m_if.tready) begin
      check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("beat", 32'({m_if.tdata, m_if.tuser, m_if.tlast}),
                                  32'(exp_q.pop_front()));
    end
  end

  // Called and returns at a falling edge.
  task automatic send_beat(input logic [W-1:0] d, input bit u, input bit l, input int gap_max);
    int n = 0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && n < 200) begin
      stall_cnt++;
      n++;
      @(negedge clk);
    end
    if (n == 200) check("accept_timeout", 32'(s_if.tready), 32'd1);
    @(negedge clk);
    s_if.tvalid = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int last_w, input int cp,
                           input int rp, input bit byp, input bit rnd, input int gap_max,
                           input bit flip, input bit model);
    bit trunc = (last_w < w);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) pix[r][c] = rnd ? W'($urandom) : W'(r * 16 + c);
    if (model) model_frame(w, h, last_w, cp, rp, byp);
    col_phase = PW'(cp);
    row_phase = PW'(rp);
    bypass    = byp;
    for (int r = 0; r < h; r++) begin
      int rw = (r == h - 1) ? last_w : w;
      for (int c = 0; c < rw; c++) begin
        send_beat(pix[r][c], (r == 0) && (c == 0), (c == rw - 1) && !(r == h - 1 && trunc),
                  gap_max);
        if (flip && r == 0 && c == 0) col_phase = col_phase ^ PW'(1);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tuser", 32'(m_if.tuser), 32'd0);
    check("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check("rst_m_tdata", 32'(m_if.tdata), 32'd0);
    check("rst_s_tready", 32'(s_if.tready), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed 4x4 and 5x2 frames at full rate.
    ready_mode = 1;
    stall_cnt = 0;
    run_frame(4, 4, 4, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    wait_drain("drain_p00");
    run_frame(4, 4, 4, 1, 1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    wait_drain("drain_p11");
    run_frame(4, 4, 4, 0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    wait_drain("drain_bypass");
    run_frame(5, 2, 5, 1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    wait_drain("drain_w5_p10");
    run_frame(5, 2, 5, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    wait_drain("drain_w5_p00");
    check("full_rate_stalls", 32'(stall_cnt), 32'd0);

    // Mid-frame phase change applies only from the next frame.
    ready_mode = 2;
    run_frame(4, 4, 4, 0, 0, 1'b0, 1'b1, 2, 1'b1, 1'b1);
    run_frame(4, 4, 4, 1, 0, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    wait_drain("drain_flip");

    // Truncated row: P holds 02 when the next frame starts.
    run_frame(4, 1, 3, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_frame(4, 4, 4, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    wait_drain("drain_trunc");

    for (int f = 0; f < 20; f++) begin
      run_frame(8, 6, 8, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0), 1'b1, 2, 1'b0, 1'b1);
    end
    wait_drain("drain_random");

    // Reset mid-frame with data still buffered.
    ready_mode = 0;
    @(negedge clk);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pix[r][c] = W'(8'ha0 + r * 16 + c);
    col_phase = '0;
    row_phase = '0;
    bypass    = 1'b0;
    for (int i = 0; i < 9; i++) send_beat(pix[i / 4][i % 4], i == 0, (i % 4) == 3, 0);
    check("pre_rst_m_tvalid", 32'(m_if.tvalid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("mid_rst_s_tready", 32'(s_if.tready), 32'd0);
    reset = 1'b0;
    ready_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 6; i++) send_beat(W'($urandom), 1'b0, (i % 3) == 2, 1);
    repeat (4) @(negedge clk);
    check("ignored_before_sof", 32'(m_if.tvalid), 32'd0);
    run_frame(4, 4, 4, 1, 1, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    ready_mode = 1;
    wait_drain("drain_after_reset");
    repeat (4) @(negedge clk);
    check("idle_at_end", 32'(m_if.tvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
